// File: rtl/des_key_sched_seq.sv
// DES key schedule generator: accepts a 64-bit key and streams the sixteen
// 48-bit round subkeys (encrypt or decrypt order), RPC subkeys per beat.
module des_key_sched_seq #(
  parameter int RPC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [63:0]       key,
  input  logic              decrypt,
  input  logic              abort,
  output logic              sk_valid,
  input  logic              sk_ready,
  output logic [48*RPC-1:0] sk,
  output logic [3:0]        sk_round,
  output logic              sk_last
);

  if (RPC != 1 && RPC != 2 && RPC != 4 && RPC != 8 && RPC != 16) begin : g_bad_rpc
    $error("des_key_sched_seq: RPC must be 1, 2, 4, 8 or 16");
  end

  // Permutation tables use FIPS 46 numbering: bit 1 is the MSB.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Rotation amount of 0-based round r in the encrypt schedule.
  function automatic logic [4:0] shift_of(input logic [3:0] r);
    return (r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15) ? 5'd1 : 5'd2;
  endfunction

  // Total rotation over n consecutive emissions starting at index start.
  // Decrypt emission e undoes the rotation of encrypt round 15-e.
  function automatic logic [4:0] cum_shift(input logic [3:0] start, input int n,
                                           input logic dec);
    logic [4:0] acc;
    logic [3:0] r;
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < n) begin
        r   = start + 4'(i);
        acc = acc + (dec ? shift_of(4'd15 - r) : shift_of(r));
      end
    end
    return acc;
  endfunction

  // Valid for n in 0..28; a full 28-bit turn returns the input.
  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [4:0] n);
    logic [55:0] t;
    t = {x, x} << n;
    return t[55:28];
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [4:0] n);
    logic [55:0] t;
    t = {x, x} >> n;
    return t[27:0];
  endfunction

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_p0, state_nxt;
  logic [27:0] c_p0, d_p0, c_nxt, d_nxt;
  logic        mode_p0, mode_nxt;
  logic [3:0]  cnt_p0, cnt_nxt;

  logic [55:0]       pc1_key;
  logic [48*RPC-1:0] sk_raw;
  logic [4:0]        adv;
  logic [27:0]       c_adv, d_adv;
  logic              last_beat;
  logic              key_parity_unused;

  assign key_parity_unused = ^{key[56], key[48], key[40], key[32],
                               key[24], key[16], key[8],  key[0]};

  for (genvar j = 0; j < 56; j++) begin : g_pc1
    assign pc1_key[55-j] = key[64-PC1[j]];
  end

  // Subkey lanes are formed combinationally from the registered C,D.
  for (genvar l = 0; l < RPC; l++) begin : g_lane
    logic [4:0]  amt;
    logic [27:0] c_r, d_r;
    logic [55:0] cd_r;

    assign amt  = mode_p0 ? cum_shift(cnt_p0, l, 1'b1) : cum_shift(cnt_p0, l + 1, 1'b0);
    assign c_r  = mode_p0 ? rotr28(c_p0, amt) : rotl28(c_p0, amt);
    assign d_r  = mode_p0 ? rotr28(d_p0, amt) : rotl28(d_p0, amt);
    assign cd_r = {c_r, d_r};

    for (genvar j = 0; j < 48; j++) begin : g_pc2
      assign sk_raw[48*(RPC-l)-1-j] = cd_r[56-PC2[j]];
    end
  end

  assign adv       = cum_shift(cnt_p0, RPC, mode_p0);
  assign c_adv     = mode_p0 ? rotr28(c_p0, adv) : rotl28(c_p0, adv);
  assign d_adv     = mode_p0 ? rotr28(d_p0, adv) : rotl28(d_p0, adv);
  assign last_beat = (cnt_p0 == 4'(16 - RPC));

  assign key_ready = (state_p0 == IDLE);
  assign sk_valid  = (state_p0 == RUN);
  assign sk        = sk_valid ? sk_raw : '0;
  assign sk_round  = sk_valid ? cnt_p0 : 4'd0;
  assign sk_last   = sk_valid & last_beat;

  always_comb begin
    state_nxt = state_p0;
    c_nxt     = c_p0;
    d_nxt     = d_p0;
    mode_nxt  = mode_p0;
    cnt_nxt   = cnt_p0;
    case (state_p0)
      IDLE: begin
        if (key_valid) begin
          state_nxt      = RUN;
          {c_nxt, d_nxt} = pc1_key;
          mode_nxt       = decrypt;
          cnt_nxt        = 4'd0;
        end
      end
      RUN: begin
        if (sk_ready) begin
          c_nxt   = c_adv;
          d_nxt   = d_adv;
          cnt_nxt = cnt_p0 + 4'(RPC);
          if (last_beat) begin
            state_nxt = IDLE;
            c_nxt     = '0;
            d_nxt     = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      c_nxt     = '0;
      d_nxt     = '0;
      cnt_nxt   = 4'd0;
    end
  end

  // Schedule state register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      c_p0     <= '0;
      d_p0     <= '0;
      mode_p0  <= 1'b0;
      cnt_p0   <= 4'd0;
    end else begin
      state_p0 <= state_nxt;
      c_p0     <= c_nxt;
      d_p0     <= d_nxt;
      mode_p0  <= mode_nxt;
      cnt_p0   <= cnt_nxt;
    end
  end

endmodule
